// File: rtl/fm_ch_scan_pkg.sv
// Shared FM channel-scan definitions: channel count, attribute field widths,
// scan FSM encodings and the per-channel record layout.
package fm_ch_scan_pkg;

   localparam int FM_NUM_CH = 18;
   localparam int CH_W      = 5;
   localparam int FNUM_W    = 10;
   localparam int BLOCK_W   = 3;
   localparam int FB_W      = 3;
   localparam int PHINC_W   = 17;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2
   } fm_state_e;

   typedef struct packed {
      logic [CH_W-1:0]    ch;
      logic [PHINC_W-1:0] phinc;
      logic               kon;
      logic               kon_evt;
      logic               koff_evt;
      logic               cnt;
      logic               cha;
      logic               chb;
      logic [FB_W-1:0]    fb;
   } fm_rec_t;

endpackage

// File: rtl/fm_phinc.sv
// Phase increment: block-scaled F-number. Width is sized so the largest
// fnum shifted by the largest block still fits without truncation.
module fm_phinc
   import fm_ch_scan_pkg::*;
(
   input  logic [FNUM_W-1:0]  fnum,
   input  logic [BLOCK_W-1:0] block,
   output logic [PHINC_W-1:0] phinc
);

   assign phinc = PHINC_W'(fnum) << block;

endmodule

// File: rtl/fm_ch_scan.sv
// Per-sample channel scanner: walks the attribute RAM one channel at a time
// and emits one handshaked record per channel with key-on/off edge events.
module fm_ch_scan
   import fm_ch_scan_pkg::*;
#(
   parameter int NUM_CH = FM_NUM_CH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic [CH_W-1:0]    ch_sel,
   input  logic               ch_chb,
   input  logic               ch_cha,
   input  logic               ch_cnt,
   input  logic               ch_kon,
   input  logic [FB_W-1:0]    ch_fb,
   input  logic [BLOCK_W-1:0] ch_block,
   input  logic [FNUM_W-1:0]  ch_fnum,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH_W-1:0]    out_ch,
   output logic [PHINC_W-1:0] out_phinc,
   output logic               out_kon,
   output logic               out_kon_evt,
   output logic               out_koff_evt,
   output logic               out_cnt,
   output logic               out_cha,
   output logic               out_chb,
   output logic [FB_W-1:0]    out_fb,
   output logic               busy,
   output logic               overrun
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   fm_state_e          state;
   logic [CH_W-1:0]    cnt_q;
   logic [NUM_CH-1:0]  prev_kon;
   logic [31:0]        prev_pad;
   logic [PHINC_W-1:0] phinc_w;
   fm_rec_t            rec;
   logic               accept;

   fm_phinc u_phinc (
      .fnum  (ch_fnum),
      .block (ch_block),
      .phinc (phinc_w)
   );

   // Pad to a full 5-bit index space so any counter value selects a bit.
   assign prev_pad = 32'(prev_kon);
   assign accept   = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt_q     <= '0;
         prev_kon  <= '0;
         rec       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= start & busy;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
                  cnt_q <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               rec.ch       <= cnt_q;
               rec.phinc    <= phinc_w;
               rec.kon      <= ch_kon;
               rec.kon_evt  <= ch_kon & ~prev_pad[cnt_q];
               rec.koff_evt <= ~ch_kon & prev_pad[cnt_q];
               rec.cnt      <= ch_cnt;
               rec.cha      <= ch_cha;
               rec.chb      <= ch_chb;
               rec.fb       <= ch_fb;
               out_valid    <= 1'b1;
               state        <= ST_PRESENT;
            end
            ST_PRESENT: begin
               if (accept) begin
                  out_valid <= 1'b0;
                  // Event history only advances for records actually consumed.
                  for (int i = 0; i < NUM_CH; i++)
                     if (cnt_q == CH_W'(i)) prev_kon[i] <= rec.kon;
                  if (cnt_q == LAST_CH) begin
                     state <= ST_IDLE;
                     cnt_q <= '0;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_FETCH;
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ch_sel       = cnt_q;
   assign out_ch       = rec.ch;
   assign out_phinc    = rec.phinc;
   assign out_kon      = rec.kon;
   assign out_kon_evt  = rec.kon_evt;
   assign out_koff_evt = rec.koff_evt;
   assign out_cnt      = rec.cnt;
   assign out_cha      = rec.cha;
   assign out_chb      = rec.chb;
   assign out_fb       = rec.fb;

endmodule

// File: tb/tb_fm_ch_scan.sv
// Scoreboard bench for fm_ch_scan: an attribute-RAM model feeds the scanner,
// expected records are queued per scan and compared as they are accepted.
module tb_fm_ch_scan;

   localparam int NCH = 18;

   typedef struct packed {
      logic [4:0]  ch;
      logic [16:0] phinc;
      logic        kon;
      logic        kon_evt;
      logic        koff_evt;
      logic        cnt;
      logic        cha;
      logic        chb;
      logic [2:0]  fb;
   } exp_rec_t;

   logic        clk, reset_n, start, out_ready;
   logic [4:0]  ch_sel, out_ch;
   logic        ch_chb, ch_cha, ch_cnt, ch_kon;
   logic [2:0]  ch_fb, ch_block, out_fb;
   logic [9:0]  ch_fnum;
   logic        out_valid, out_kon, out_kon_evt, out_koff_evt, out_cnt, out_cha, out_chb;
   logic [16:0] out_phinc;
   logic        busy, overrun;

   logic [9:0]  a_fnum [32];
   logic [2:0]  a_block[32];
   logic [2:0]  a_fb   [32];
   logic        a_kon  [32];
   logic        a_cnt  [32];
   logic        a_cha  [32];
   logic        a_chb  [32];
   logic [31:0] prev_m;

   exp_rec_t sb_q[$];
   int n_chk, n_err, cyc, bcyc;

   fm_ch_scan #(.NUM_CH(NCH)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ch_sel(ch_sel),
      .ch_chb(ch_chb), .ch_cha(ch_cha), .ch_cnt(ch_cnt), .ch_kon(ch_kon),
      .ch_fb(ch_fb), .ch_block(ch_block), .ch_fnum(ch_fnum),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_phinc(out_phinc), .out_kon(out_kon), .out_kon_evt(out_kon_evt),
      .out_koff_evt(out_koff_evt), .out_cnt(out_cnt), .out_cha(out_cha),
      .out_chb(out_chb), .out_fb(out_fb), .busy(busy), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      ch_fnum  = a_fnum[ch_sel];
      ch_block = a_block[ch_sel];
      ch_fb    = a_fb[ch_sel];
      ch_kon   = a_kon[ch_sel];
      ch_cnt   = a_cnt[ch_sel];
      ch_cha   = a_cha[ch_sel];
      ch_chb   = a_chb[ch_sel];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_scan(input int n);
      exp_rec_t e;
      for (int c = 0; c < n; c++) begin
         e.ch       = 5'(c);
         e.phinc    = 17'(int'(a_fnum[c]) * (1 << a_block[c]));
         e.kon      = a_kon[c];
         e.kon_evt  = a_kon[c] & ~prev_m[c];
         e.koff_evt = ~a_kon[c] & prev_m[c];
         e.cnt      = a_cnt[c];
         e.cha      = a_cha[c];
         e.chb      = a_chb[c];
         e.fb       = a_fb[c];
         sb_q.push_back(e);
      end
   endtask

   // Runs one scan; optional stall channel, overrun-start channel, reset channel.
   task automatic do_scan(input int stall_ch, input int ovr_ch, input int rst_ch,
                          input bit chk_spacing, output int busy_cyc);
      exp_rec_t got, e, snap;
      int  stall_n, hold_n, ovr_st, last_acc;
      bit  done, rst_done;
      stall_n = 0; hold_n = 0; ovr_st = 0; last_acc = -1;
      done = 0; rst_done = 0; busy_cyc = 0; snap = '0;
      push_scan(rst_ch >= 0 ? rst_ch : NCH);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int it = 0; it < 2000; it++) begin
         got = {out_ch, out_phinc, out_kon, out_kon_evt, out_koff_evt,
                out_cnt, out_cha, out_chb, out_fb};
         if (busy) busy_cyc++;
         if (rst_done) begin
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_sel", 32'(ch_sel), 0);
            chk("rst_phinc", 32'(out_phinc), 0);
            reset_n = 1'b1;
            sb_q.delete();
            prev_m = '0;
            done = 1;
            break;
         end
         if (ovr_st == 1) begin
            start = 1'b0;
            chk("overrun_pulse", 32'(overrun), 1);
            ovr_st = 2;
         end else if (ovr_st == 2) begin
            chk("overrun_clear", 32'(overrun), 0);
            ovr_st = 3;
         end
         if (out_valid) chk("sel_match", 32'(ch_sel), 32'(out_ch));
         if (rst_ch >= 0 && out_valid && out_ch == 5'(rst_ch)) begin
            reset_n = 1'b0;
            rst_done = 1;
            @(negedge clk);
            continue;
         end
         if (ovr_ch >= 0 && ovr_st == 0 && out_valid && out_ch == 5'(ovr_ch)) begin
            start = 1'b1;
            ovr_st = 1;
         end
         if (stall_ch >= 0 && out_valid && out_ch == 5'(stall_ch)) begin
            if (hold_n == 0) snap = got;
            chk("stall_stable", 32'(got), 32'(snap));
            hold_n++;
            if (stall_n < 10) begin
               out_ready = 1'b0;
               stall_n++;
            end else out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e = sb_q.pop_front();
               chk("rec", 32'(got), 32'(e));
               prev_m[e.ch] = e.kon;
               if (chk_spacing && last_acc >= 0) chk("spacing", 32'(cyc - last_acc), 2);
               last_acc = cyc;
            end
         end
         if (!busy && (ovr_ch < 0 || ovr_st == 3)) begin
            done = 1;
            break;
         end
         @(negedge clk);
      end
      if (!done) chk("scan_timeout", 1, 0);
      chk("sb_drained", 32'(sb_q.size()), 0);
      if (stall_ch >= 0) chk("stall_hold", 32'(hold_n), 11);
      out_ready = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(out_valid), 0);
   endtask

   initial begin
      n_chk = 0; n_err = 0; cyc = 0; prev_m = '0;
      reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 32; c++) begin
         a_fnum[c] = '0; a_block[c] = '0; a_fb[c] = '0; a_kon[c] = 1'b0;
         a_cnt[c] = 1'b0; a_cha[c] = 1'b0; a_chb[c] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_sel", 32'(ch_sel), 0);
      chk("reset_overrun", 32'(overrun), 0);
      chk("reset_phinc", 32'(out_phinc), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // All-zero attributes: 18 records, 2 cycles apart, 36 busy cycles.
      do_scan(-1, -1, -1, 1'b1, bcyc);
      chk("busy_cycles", 32'(bcyc), 36);

      a_fnum[5] = 10'h3FF; a_block[5] = 3'd7;
      a_fnum[2] = 10'h155; a_block[2] = 3'd0;
      a_kon[3] = 1'b1;
      for (int c = 8; c < NCH; c++) begin
         a_fnum[c] = 10'($urandom); a_block[c] = 3'($urandom);
         a_fb[c] = 3'($urandom); a_cnt[c] = 1'($urandom);
         a_cha[c] = 1'($urandom); a_chb[c] = 1'($urandom);
      end
      do_scan(-1, -1, -1, 1'b0, bcyc);
      chk("busy_cycles2", 32'(bcyc), 36);

      // kon held: no event on ch 3; stall ch 7 for 10 cycles.
      a_fnum[5] = 10'h155; a_block[5] = 3'd0;
      do_scan(7, -1, -1, 1'b0, bcyc);

      // kon released: koff event; start during the 4th record is an overrun.
      a_kon[3] = 1'b0;
      do_scan(-1, 3, -1, 1'b0, bcyc);
      chk("busy_cycles_ovr", 32'(bcyc), 36);

      for (int c = 0; c < NCH; c++) a_kon[c] = 1'($urandom);
      do_scan(-1, 17, -1, 1'b0, bcyc);

      for (int c = 0; c < NCH; c++) a_kon[c] = 1'($urandom);
      a_kon[0] = 1'b1; a_kon[12] = 1'b1;
      do_scan(-1, -1, 9, 1'b0, bcyc);
      do_scan(-1, -1, -1, 1'b0, bcyc);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
